// File: rtl/crypto_kem_keypair_sdiv_16s_16s_seq.sv
// Sequential 16s / 16s signed divider: restoring division on operand magnitudes,
// signs applied in a final fix-up step; quotient truncates toward zero.
module crypto_kem_keypair_sdiv_16s_16s_seq #(
   parameter int unsigned ID         = 32'd1,
   parameter int unsigned din0_WIDTH = 32'd16,
   parameter int unsigned din1_WIDTH = 32'd16,
   parameter int unsigned dout_WIDTH = 32'd16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] quo,
   output logic [dout_WIDTH-1:0] rem,
   output logic                  dbz
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] dvd_q, dvd_d;   // dividend magnitude shifts out MSB-first, quotient bits shift in
   logic [15:0] dvs_q, dvs_d;
   logic [16:0] prem_q, prem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        neg_a_q, neg_a_d;
   logic        neg_b_q, neg_b_d;
   logic [15:0] quo_q, quo_d;
   logic [15:0] rem_q, rem_d;
   logic        dbz_q, dbz_d;

   logic [16:0] shifted;
   logic        fits;
   logic [31:0] id_unused;

   assign id_unused = ID;

   assign shifted = {prem_q[15:0], dvd_q[15]};
   assign fits    = (shifted >= {1'b0, dvs_q});

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Negating 0x8000 in 16 bits yields 0x8000, the correct magnitude of -32768.
               dvd_d   = din0[15] ? 16'(-din0) : din0;
               dvs_d   = din1[15] ? 16'(-din1) : din1;
               neg_a_d = din0[15];
               neg_b_d = din1[15];
               prem_d  = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            prem_d = fits ? (shifted - {1'b0, dvs_q}) : shifted;
            dvd_d  = {dvd_q[14:0], fits};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // A zero divisor accepts every trial subtraction, leaving |din0| as the remainder.
            dbz_d   = (dvs_q == 16'd0);
            quo_d   = (dvs_q == 16'd0)   ? 16'hFFFF
                    : (neg_a_q ^ neg_b_q) ? 16'(-dvd_q) : dvd_q;
            rem_d   = neg_a_q ? 16'(-prem_q[15:0]) : prem_q[15:0];
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quo       = quo_q;
   assign rem       = rem_q;
   assign dbz       = dbz_q;

endmodule

// File: doc/crypto_kem_keypair_sdiv_16s_16s_seq.md
CRYPTO_KEM_KEYPAIR_SDIV_16S_16S_SEQ -- requirements
Module: crypto_kem_keypair_sdiv_16s_16s_seq

Interface
REQ-001 Parameter ID, default 32'd1: instance tag; has no functional effect.
REQ-002 Parameter din0_WIDTH, default 32'd16: dividend width; only 16 is supported.
REQ-003 Parameter din1_WIDTH, default 32'd16: divisor width; only 16 is supported.
REQ-004 Parameter dout_WIDTH, default 32'd16: quotient and remainder width; only 16 is supported.
REQ-005 ap_clk  in  1  single clock; all state changes on rising edge.
REQ-006 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  operand pair on din0/din1 is valid.
REQ-008 in_ready  out  1  block accepts operands this cycle.
REQ-009 din0  in  16  signed dividend.
REQ-010 din1  in  16  signed divisor.
REQ-011 out_valid  out  1  quo/rem/dbz hold a result.
REQ-012 out_ready  in  1  consumer takes the result this cycle.
REQ-013 quo  out  16  signed quotient.
REQ-014 rem  out  16  signed remainder.
REQ-015 dbz  out  1  divide-by-zero flag for the current result.

Function
REQ-016 The block SHALL be the sequential inverse of the 16s x 16s -> 16 multiplier: din0 = quo*din1 + rem (mod 2^16), quotient truncated toward zero, rem carrying the sign of din0, |rem| < |din1|.
REQ-017 FSM states SHALL be IDLE, CALC, FIX and DONE, with no other reachable state.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 Acceptance SHALL occur when in_valid=1 and in_ready=1; operands are latched at that edge, later changes on din0/din1 are ignored, and the FSM goes IDLE->CALC.
REQ-020 At acceptance the block SHALL store the unsigned 16-bit magnitudes |din0| and |din1|, with |-32768| = 0x8000, and the two sign bits; the iteration counter SHALL be cleared to 0.
REQ-021 CALC SHALL perform one restoring-division step per cycle (17-bit partial remainder, shift-in MSB-first) for exactly 16 cycles; on the 16th step the FSM goes CALC->FIX.
REQ-022 FIX SHALL apply the signs (quotient negated iff signs differ, remainder negated iff din0 negative) and register quo/rem/dbz, then go FIX->DONE.
REQ-023 Latency: out_valid SHALL rise exactly 18 cycles after the acceptance cycle, i.e. 1 load + 16 CALC + 1 FIX edge.
REQ-024 DONE SHALL hold quo/rem/dbz stable until out_ready=1, then go DONE->IDLE at that edge; out_ready outside DONE SHALL be ignored.
REQ-025 Throughput SHALL be one division per 19 cycles or more; there is no overlap of operations and no result buffering beyond one entry.
REQ-026 Divisor 0: the block SHALL output quo=16'hFFFF, rem=din0 and dbz=1, with the same latency as a normal division.
REQ-027 -32768 / -1: the block SHALL output quo=16'h8000 (two's-complement wrap), rem=0 and dbz=0.
REQ-028 dbz SHALL be 0 for every non-zero divisor.
REQ-029 quo/rem/dbz SHALL be held (not cleared) in IDLE, CALC and FIX until overwritten in FIX.

Reset
REQ-030 When ap_rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, quo=0, rem=0, dbz=0, out_valid=0 and in_ready=1 after deassertion.
REQ-031 Reset asserted mid-CALC, FIX or DONE SHALL abort the operation with no result emitted.
REQ-032 The first acceptance SHALL be possible on the first rising edge after ap_rst_n deasserts.

Verification
REQ-033 din0=100, din1=7, out_ready=1 -> out_valid 18 cycles after accept; quo=14, rem=2, dbz=0.
REQ-034 din0=-100, din1=7 -> quo=-14, rem=-2; din0=100, din1=-7 -> quo=-14, rem=2; din0=-100, din1=-7 -> quo=14, rem=-2.
REQ-035 din0=-32768, din1=-1 -> quo=16'h8000, rem=0, dbz=0; din0=1234, din1=0 -> quo=16'hFFFF, rem=1234, dbz=1.
REQ-036 out_ready held 0 for 10 cycles after out_valid, with in_valid=1 throughout -> outputs stable, in_ready=0, no new accept until 1 cycle after the out_ready handshake.
REQ-037 ap_rst_n pulsed low at CALC step 8 -> out_valid stays 0, outputs read 0, and the next operation (500/-3) returns quo=-166, rem=2.
REQ-038 Randomized 10^5 operand pairs checked against the truncating C reference model for quo/rem/dbz and fixed 18-cycle latency.
